// File: rtl/ex_result_stage.sv
// EX-stage result register: two-entry skid buffer between the ALU and MEM/WB,
// plus the architectural Z/V/N flag register and the HLT latch.
module ex_result_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_ovfl,
  input  logic [REG_W-1:0]  in_dst,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_wr_en,
  output logic [3:0]        out_opcode,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic              wr_en;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] result;
  } entry_t;

  state_t state_reg, state_next;
  entry_t head_reg, skid_reg, in_entry;
  logic   halted_reg;
  logic   flag_z_reg, flag_v_reg, flag_n_reg;

  logic accept, xfer;
  logic load_head_in, load_skid_in, move_skid;
  logic upd_zvn, upd_z;

  assign in_entry = '{opcode: in_opcode, wr_en: in_wr_en, dst: in_dst, result: in_result};

  assign in_ready  = (state_reg != ST_FULL) && !halted_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign xfer      = out_valid && out_ready;

  assign out_result = head_reg.result;
  assign out_dst    = head_reg.dst;
  assign out_wr_en  = head_reg.wr_en;
  assign out_opcode = head_reg.opcode;
  assign flag_z     = flag_z_reg;
  assign flag_v     = flag_v_reg;
  assign flag_n     = flag_n_reg;
  assign halted     = halted_reg;

  // Occupancy transitions; flush overrides everything and empties the buffer.
  always_comb begin
    state_next   = state_reg;
    load_head_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_ONE;
            load_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_next   = ST_FULL;
            load_skid_in = 1'b1;
          end else if (xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_next = ST_ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    upd_zvn = 1'b0;
    upd_z   = 1'b0;
    case (in_opcode)
      OP_ADD, OP_SUB:                 upd_zvn = 1'b1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_EMPTY;
      head_reg   <= '0;
      skid_reg   <= '0;
      halted_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_v_reg <= 1'b0;
      flag_n_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_head_in) begin
        head_reg <= in_entry;
      end else if (move_skid) begin
        head_reg <= skid_reg;
      end
      if (load_skid_in) begin
        skid_reg <= in_entry;
      end
      // Flags follow the accept, not the drain, so a downstream stall never delays them.
      if (accept) begin
        if (upd_zvn || upd_z) begin
          flag_z_reg <= (in_result == '0);
        end
        if (upd_zvn) begin
          flag_v_reg <= in_ovfl;
          flag_n_reg <= in_result[DATA_W-1];
        end
        if (in_opcode == OP_HLT) begin
          halted_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Registered output stage that sits directly downstream of the ALU (ADD/SUB/XOR/RED/shift/PADDSB) in the EX stage. It captures each ALU result with its destination-register info into a two-entry skid buffer using a valid/ready handshake. It maintains the architectural Z/V/N flag register under per-opcode update rules and latches HLT. It presents results to the MEM/writeback side with one cycle of latency and full throughput.

## Interface
- DATA_W, 16, result/operand width
- REG_W, 4, destination register index width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept (= skid entry empty, not halted)
- in_opcode  input  4  opcode of producing instruction
- in_result  input  DATA_W  ALU output (RED output arrives already sign-extended)
- in_ovfl  input  1  ALU signed-overflow indication
- in_dst  input  REG_W  destination register
- in_wr_en  input  1  instruction writes register file
- flush  input  1  synchronous squash of all held and incoming entries
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head
- out_result  output  DATA_W  head result
- out_dst  output  REG_W  head destination
- out_wr_en  output  1  head register write enable
- out_opcode  output  4  head opcode
- flag_z, flag_v, flag_n  output  1 each  architectural flags
- halted  output  1  HLT accepted

## Operation
- Accept = in_valid & in_ready & ~flush. Transfer out = out_valid & out_ready.
- Storage: head register plus one skid register, in FIFO order. Occupancy states: EMPTY, ONE (head only), FULL (head + skid).
- EMPTY: accept → ONE.
- ONE: accept with transfer → ONE, with the new entry in head. Accept without transfer → FULL, with the new entry in skid. Transfer alone → EMPTY.
- FULL: in_ready=0. Transfer → ONE, with skid moved to head.
- Flag update on accept only. Z = (in_result==0), N = in_result[15], V = in_ovfl.
  - Opcodes 0000 ADD and 0001 SUB update Z, V and N.
  - 0010 XOR, 0100 SLL, 0101 SRA and 0110 ROR update Z only.
  - 0011 RED, 0111 PADDSB and all other opcodes leave the flags unchanged.
- HLT (1111) accept: the entry is enqueued normally and halted=1. in_ready is then held 0 until reset. Held entries still drain.
- flush: the next state is EMPTY. The incoming beat in the same cycle is dropped. Flags and halted are unchanged. Flush has priority over accept and transfer.
- Output fields always reflect head. When out_valid=0 they hold their last value, and nothing depends on them.

## Timing
- Reset (async assert, sync deassert by system): out_valid=0, out_result=0, out_dst=0, out_wr_en=0, out_opcode=0, flag_z=0, flag_v=0, flag_n=0, halted=0, state EMPTY, in_ready=1.
- Latency: an accept at edge k gives out_valid=1 with that entry's data after edge k.
- Throughput: one per cycle while out_ready=1.
- in_ready and out_valid are registered-state decodes. There is no combinational in→out path.
- Flags are visible the cycle after accept, independent of downstream stall.
- Backpressure: out_ready low while ONE and an accept occurs → FULL. in_ready falls after that edge. No beat is lost.
- Simultaneous transfer and accept in FULL is impossible because in_ready=0.
- Reset mid-operation discards all entries and clears the flags.

## Test plan
- Reset → out_valid=0, in_ready=1, all flags 0, halted=0.
- Stream with out_ready=1: ADD result 0x0000 with in_ovfl=1, then SUB result 0x8001 → after the 1st edge Z=1,V=1,N=0; after the 2nd edge Z=0,V=0,N=1. Outputs lag by exactly one cycle.
- RED result 0xFFFE following ADD result 0 → flags stay Z=1; out_result=0xFFFE. XOR result 0x0004 → Z=0, and V/N are unchanged.
- out_ready=0 with 3 beats A,B,C offered → A and B accepted, in_ready=0, C held at the input. Raise out_ready → A, B, C emerge in order with no loss or duplication.
- FULL state plus flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flags unchanged, the incoming beat is not emitted.
- HLT accepted → halted=1, in_ready=0 persistently. The HLT entry drains with out_opcode=1111. Asserting rst_n=0 asynchronously mid-cycle clears halted and the outputs immediately.
